axi_read_master: RTL and testbench

Issues AXI read bursts on behalf of a local requester and sits directly upstream of the read slave. It drives the AR channel and consumes the R channel. Returned beats are buffered in a 4-entry FIFO and handed to the requester through a valid/ready stream. An end-of-transaction pulse reports the burst as complete and, when error checking is compiled in, whether it was well-formed.

---
 rtl/axi_read_master_pkg.sv | 24 ++
 rtl/axi_read_master_fifo.sv | 47 ++++
 rtl/axi_read_master.sv | 172 +++++++++++++++++
 tb/tb_axi_read_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_master_pkg.sv
// Shared types for the AXI read master: burst and response encodings, FSM states.
package axi_read_master_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

endpackage

// File: rtl/axi_read_master_fifo.sv
// Synchronous FIFO buffering returned R beats; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module axi_read_master_fifo #(
  parameter int unsigned Width = 35,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi_read_master.sv
// AXI read master: one outstanding burst, R beats buffered in a FIFO and
// streamed to the requester. Optional protocol/response checking is enabled
// by defining AXI_READ_MASTER_CHECK_EN.
module axi_read_master
  import axi_read_master_pkg::*;
#(
  parameter int unsigned BusWidth  = 32,
  parameter int unsigned TagBits   = 4,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TagBits-1:0]  req_id,
  input  logic [BusWidth-1:0] req_addr,
  input  logic [1:0]          req_len,
  input  logic [1:0]          req_size,
  input  logic [1:0]          req_burst,
  output logic [TagBits-1:0]  ARID,
  output logic [BusWidth-1:0] ARADDR,
  output logic [3:0]          ARLEN,
  output logic [1:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic [1:0]          ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [TagBits-1:0]  RID,
  input  logic [BusWidth-1:0] RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BusWidth-1:0] out_data,
  output logic [1:0]          out_resp,
  output logic                out_last,
  output logic                done,
  output logic                err
);

  state_e              state;
  state_e              state_n;
  logic [TagBits-1:0]  l_id;
  logic [BusWidth-1:0] l_addr;
  logic [1:0]          l_len;
  logic [1:0]          l_size;
  burst_e              l_burst;
  logic [2:0]          beat_cnt;
  logic                err_acc;
  logic                beat_push;
  logic                beat_end;
  logic                beat_bad;
  logic                stray_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BusWidth+2:0] fifo_rdata;

`ifdef AXI_READ_MASTER_CHECK_EN
  logic [2:0] beat_cnt_n;
  logic [2:0] len_beats;
  assign beat_cnt_n = beat_cnt + 3'd1;
  assign len_beats  = {1'b0, l_len} + 3'd1;
  // The burst ends on RLAST or on the expected beat count, whichever comes first.
  assign beat_end   = RLAST || (beat_cnt_n == len_beats);
  assign beat_bad   = (RID != l_id) || (RRESP != RESP_OKAY) ||
                      (RLAST != (beat_cnt_n == len_beats));
  assign stray_ok   = 1'b1;
`else
  logic unused_rid;
  assign unused_rid = ^RID;
  assign beat_end   = RLAST;
  assign beat_bad   = 1'b0;
  assign stray_ok   = 1'b0;
`endif

  assign ARID      = l_id;
  assign ARADDR    = l_addr;
  assign ARLEN     = {2'b00, l_len};
  assign ARSIZE    = l_size;
  assign ARBURST   = l_burst;
  assign ARLOCK    = '0;
  assign ARCACHE   = '0;
  assign ARPROT    = '0;
  assign beat_push = (state == ST_DATA) && RVALID && RREADY;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = !ARESET;
        RREADY    = stray_ok && !ARESET;
        if (req_valid && req_ready) state_n = ST_ADDR;
      end
      ST_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_n = ST_DATA;
      end
      ST_DATA: begin
        RREADY = !fifo_full || out_ready;
        if (RVALID && RREADY && beat_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch, beat counter and sticky error accumulation.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      l_id     <= '0;
      l_addr   <= '0;
      l_len    <= '0;
      l_size   <= '0;
      l_burst  <= BURST_FIXED;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
    end else if (req_valid && req_ready) begin
      l_id     <= req_id;
      l_addr   <= req_addr;
      l_len    <= req_len;
      l_size   <= req_size;
      l_burst  <= burst_e'(req_burst);
      beat_cnt <= '0;
      err_acc  <= 1'b0;
    end else if (beat_push) begin
      beat_cnt <= beat_cnt + 3'd1;
      err_acc  <= err_acc | beat_bad;
    end
  end

  // Completion pulse, registered alongside the return to IDLE.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= beat_push && beat_end;
      err  <= beat_push && beat_end && (err_acc || beat_bad);
    end
  end

  axi_read_master_fifo #(
    .Width (BusWidth + 3),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (beat_push),
    .pop   (out_ready),
    .wdata ({RDATA, RRESP, RLAST}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_resp, out_last} = fifo_empty ? '0 : fifo_rdata;

endmodule

// File: tb/tb_axi_read_master.sv
// Self-checking bench for axi_read_master: directed scenarios plus randomized
// bursts, checked against a transaction-level model (beat queue + burst phase).
module tb_axi_read_master;

`ifdef AXI_READ_MASTER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic [1:0]  req_len, req_size, req_burst;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE, ARBURST, ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_resp;
  logic        out_last, done, err;

  always #5 ACLK = ~ACLK;

  axi_read_master #(.BusWidth(32), .TagBits(4), .FifoDepth(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_resp(out_resp), .out_last(out_last), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents and burst phase (0 idle, 1 addr, 2 data).
  logic [34:0] mq[$];
  int          mphase = 0;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [1:0]  m_len, m_size, m_burst;
  int          mcnt;
  bit          merr, exp_done, exp_err, prev_rst;
  bit          t_req, t_ar, t_r, dut_pop;

  logic [31:0] bd  [8];
  logic [1:0]  brs [8];
  logic        bl  [8];
  logic [3:0]  bid [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, compare against the model, advance the model across the edge.
  task automatic cycle();
    bit exp_rr, bad, fin;
    #1;
    exp_rr  = (mphase == 2 && (mq.size() < 4 || out_ready)) || (CHK && mphase == 0);
    dut_pop = out_valid && out_ready;
    t_req   = !ARESET && mphase == 0 && req_valid;
    t_ar    = !ARESET && mphase == 1 && ARREADY;
    t_r     = !ARESET && mphase == 2 && RVALID && exp_rr;
    if (prev_rst && ARESET) begin
      chk("rst_ctrl", 64'({req_ready, ARVALID, RREADY, out_valid, done, err, out_last}), 64'(0));
      chk("rst_ar", 64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}), 64'(0));
      chk("rst_out", 64'({out_data, out_resp}), 64'(0));
    end else if (ARESET) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
    end else begin
      chk("req_ready", 64'(req_ready), 64'(mphase == 0));
      chk("arvalid", 64'(ARVALID), 64'(mphase == 1));
      if (mphase == 1)
        chk("ar_fields", 64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}),
            64'({m_id, m_addr, 2'b00, m_len, m_size, m_burst, 9'd0}));
      chk("rready", 64'(RREADY), 64'(exp_rr));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0)
        chk("out_beat", 64'({out_data, out_resp, out_last}), 64'(mq[0]));
      chk("done", 64'(done), 64'(exp_done));
      if (exp_done) chk("err", 64'(err), 64'(exp_err));
    end
    if (ARESET) begin
      mphase = 0; mq.delete(); exp_done = 0; prev_rst = 1;
    end else begin
      prev_rst = 0; exp_done = 0;
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (t_req) begin
        m_id = req_id; m_addr = req_addr; m_len = req_len; m_size = req_size;
        m_burst = req_burst; mcnt = 0; merr = 0; mphase = 1;
      end else if (t_ar) begin
        mphase = 2;
      end else if (t_r) begin
        mq.push_back({RDATA, RRESP, RLAST});
        mcnt++;
        bad  = (RID !== m_id) || (RRESP !== 2'b00) || (RLAST != (mcnt == int'(m_len) + 1));
        merr = merr | bad;
        fin  = RLAST || (CHK && mcnt == int'(m_len) + 1);
        if (fin) begin exp_done = 1; exp_err = CHK && merr; mphase = 0; end
      end
    end
    @(negedge ACLK);
  endtask

  task automatic issue_req(input logic [3:0] id, input logic [31:0] a, input logic [1:0] len,
                           input logic [1:0] sz, input logic [1:0] bu);
    int n = 0;
    req_id = id; req_addr = a; req_len = len; req_size = sz; req_burst = bu; req_valid = 1'b1;
    do begin cycle(); n++; end while (!t_req && n < 50);
    req_valid = 1'b0;
    chk("req_accept", 64'(t_req), 64'(1));
  endtask

  task automatic ar_phase(input int wait_cyc);
    int n = 0;
    ARREADY = 1'b0;
    repeat (wait_cyc) cycle();
    ARREADY = 1'b1;
    do begin cycle(); n++; end while (!t_ar && n < 50);
    ARREADY = 1'b0;
    chk("ar_accept", 64'(t_ar), 64'(1));
  endtask

  // mode 0: random RVALID gaps and out_ready; 1: both high; 2: out_ready low.
  task automatic r_phase(input int nb, input int mode);
    int idx = 0;
    int n = 0;
    RVALID = 1'b0;
    while (idx < nb && n < 300) begin
      if (!RVALID) RVALID = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      RDATA = bd[idx]; RRESP = brs[idx]; RLAST = bl[idx]; RID = bid[idx];
      case (mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      cycle(); n++;
      if (t_r) begin idx++; RVALID = 1'b0; end
    end
    RVALID = 1'b0; RLAST = 1'b0;
    chk("r_beats", 64'(idx), 64'(nb));
  endtask

  task automatic drain(input int cyc, output int popped);
    out_ready = 1'b1; popped = 0;
    repeat (cyc) begin cycle(); if (dut_pop) popped++; end
  endtask

  task automatic fill(input int nb, input logic [3:0] id, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < nb; i++) begin
      bd[i]  = rnd ? $urandom : base + 32'(i);
      brs[i] = 2'b00; bl[i] = (i == nb - 1); bid[i] = id;
    end
  endtask

  initial begin
    int p;
    int len;
    logic [3:0] id;
    ARESET = 1'b1; req_valid = 0; req_id = 0; req_addr = 0; req_len = 0; req_size = 0;
    req_burst = 0; ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    out_ready = 0;
    @(negedge ACLK);
    cycle(); cycle();
    ARESET = 1'b0;
    cycle();

    // INCR burst with delayed ARREADY, data 0xA0..0xA3.
    fill(4, 4'h6, 32'hA0, 0);
    issue_req(4'h6, 32'h100, 2'd3, 2'b10, 2'b01);
    ar_phase(2);
    r_phase(4, 1);
    chk("incr_done", 64'(done), 64'(1));
    chk("incr_err", 64'(err), 64'(0));
    drain(6, p);

    // Backpressure: FIFO absorbs 4 beats with no consumer, then drains.
    fill(4, 4'h2, 0, 1);
    issue_req(4'h2, $urandom, 2'd3, 2'b10, 2'b01);
    ar_phase(0);
    r_phase(4, 2);
    chk("bp_done", 64'(done), 64'(1));
    chk("bp_rready_after", 64'(RREADY), 64'(CHK));
    drain(8, p);
    chk("bp_drain_count", 64'(p), 64'(4));

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    fill(4, 4'h1, 0, 1);
    issue_req(4'h1, $urandom, 2'd3, 2'b01, 2'b01);
    ar_phase(1);
    r_phase(4, 2);
    fill(1, 4'h7, 0, 1);
    issue_req(4'h7, $urandom, 2'd0, 2'b10, 2'b00);
    ar_phase(0);
    r_phase(1, 1);
    out_ready = 1'b0;
    chk("full_done", 64'(done), 64'(1));
    drain(8, p);
    chk("full_occupancy", 64'(p), 64'(4));

    // Malformed bursts: early RLAST, RID mismatch, SLVERR.
    fill(1, 4'h9, 0, 1);
    issue_req(4'h9, $urandom, 2'd1, 2'b10, 2'b01);
    ar_phase(0); r_phase(1, 0);
    chk("early_last_done", 64'(done), 64'(1));
    chk("early_last_err", 64'(err), 64'(CHK));
    fill(1, 4'h5, 0, 1);
    issue_req(4'h3, $urandom, 2'd0, 2'b10, 2'b01);
    ar_phase(0); r_phase(1, 0);
    chk("rid_err", 64'(err), 64'(CHK));
    fill(1, 4'h4, 0, 1); brs[0] = 2'b10;
    issue_req(4'h4, $urandom, 2'd0, 2'b10, 2'b01);
    ar_phase(0); r_phase(1, 0);
    chk("rresp_err", 64'(err), 64'(CHK));
    drain(6, p);

    // Back-to-back: next request already pending in the done cycle.
    fill(2, 4'hA, 0, 1);
    issue_req(4'hA, $urandom, 2'd1, 2'b10, 2'b01);
    ar_phase(0); r_phase(2, 1);
    chk("b2b_done", 64'(done), 64'(1));
    chk("b2b_req_ready", 64'(req_ready), 64'(1));
    issue_req(4'hB, 32'h2000, 2'd0, 2'b10, 2'b01);
    chk("b2b_arvalid", 64'(ARVALID), 64'(1));
    chk("b2b_arid", 64'(ARID), 64'(4'hB));
    fill(1, 4'hB, 0, 1);
    ar_phase(0); r_phase(1, 1);
    drain(6, p);

    // Reset in the middle of DATA with two beats buffered.
    out_ready = 1'b0;
    fill(4, 4'hC, 0, 1);
    issue_req(4'hC, $urandom, 2'd3, 2'b10, 2'b01);
    ar_phase(0); r_phase(2, 2);
    ARESET = 1'b1;
    cycle(); cycle();
    ARESET = 1'b0;
    cycle(); cycle();

    // Randomized bursts.
    for (int k = 0; k < 30; k++) begin
      id  = 4'($urandom);
      len = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) begin
        bd[i]  = $urandom;
        brs[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        bl[i]  = (i == len);
        bid[i] = id;
      end
      issue_req(id, $urandom, 2'(len), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      ar_phase($urandom_range(0, 3));
      r_phase(len + 1, 0);
      if ($urandom_range(0, 1) != 0) cycle();
    end
    drain(12, p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
